// File: rtl/icache_req_fifo_pkg.sv
// -----------------------------------------------------------------------------
// icache_req_fifo_pkg
//   Shared definitions for the icache request FIFO slice:
//     - word-length encoding carried with every queued request
//     - request entry width helper ({addr, wordlen})
// -----------------------------------------------------------------------------
package icache_req_fifo_pkg;

    typedef enum logic [1:0] {
        ICACHE_WL_BYTE = 2'b00,
        ICACHE_WL_HALF = 2'b01,
        ICACHE_WL_WORD = 2'b10,
        ICACHE_WL_RSVD = 2'b11
    } icache_wl_e;

    localparam int ICACHE_ADDRBITS = 32;
    localparam int ICACHE_QREQ_W   = ICACHE_ADDRBITS + 2;

    // Entry width for an arbitrary address width: address plus 2-bit wordlen.
    function automatic int icache_qreq_w(input int addrbits);
        return addrbits + 2;
    endfunction

endpackage

// File: rtl/icache_req_fifo_if.sv
// -----------------------------------------------------------------------------
// icache_req_fifo_if
//   Handshake bundle between the request producers (miss/prefetch logic) and
//   the request FIFO, plus the status flags seen by the fetch FSM.
//   Modports:
//     master : producer/consumer side (drives push/pop/flush/err_clr)
//     slave  : FIFO side (drives head entry, level and flags)
// -----------------------------------------------------------------------------
interface icache_req_fifo_if #(
    parameter int ADDRBITS     = 32,
    parameter int QUEUECNTBITS = 3
);
    logic                    flush;
    logic                    push;
    logic [ADDRBITS-1:0]     push_addr;
    logic [1:0]              push_wordlen;
    logic                    pop;
    logic [ADDRBITS-1:0]     pop_addr;
    logic [1:0]              pop_wordlen;
    logic                    not_empty;
    logic                    full;
    logic                    almost_full;
    logic [QUEUECNTBITS:0]   level;
    logic                    err_overflow;
    logic                    err_underflow;
    logic                    err_clr;

    modport master (
        output flush, push, push_addr, push_wordlen, pop, err_clr,
        input  pop_addr, pop_wordlen, not_empty, full, almost_full, level,
               err_overflow, err_underflow
    );

    modport slave (
        input  flush, push, push_addr, push_wordlen, pop, err_clr,
        output pop_addr, pop_wordlen, not_empty, full, almost_full, level,
               err_overflow, err_underflow
    );
endinterface

// File: rtl/icache_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// icache_fifo_ctrl
//   Pointer / flag / error controller for the icache request FIFO.
//   Ports:
//     clk, reset_n            clock, asynchronous active-low reset
//     flush, push, pop        queue controls (flush wins over push/pop)
//     err_clr                 clears the sticky error flags
//     wr_en, wr_idx           storage write strobe and slot
//     rd_idx                  head slot for the read mux
//     not_empty, full,
//     almost_full, level      status, all derived from registered state
//     err_overflow,
//     err_underflow           sticky error flags
// -----------------------------------------------------------------------------
module icache_fifo_ctrl #(
    parameter int QUEUECNTBITS = 3,
    parameter int AF_MARGIN    = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    flush,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    err_clr,
    output logic                    wr_en,
    output logic [QUEUECNTBITS-1:0] wr_idx,
    output logic [QUEUECNTBITS-1:0] rd_idx,
    output logic                    not_empty,
    output logic                    full,
    output logic                    almost_full,
    output logic [QUEUECNTBITS:0]   level,
    output logic                    err_overflow,
    output logic                    err_underflow
);
    localparam int PW        = QUEUECNTBITS + 1;
    localparam int QUEUESIZE = 1 << QUEUECNTBITS;
    localparam logic [PW-1:0] AF_LEVEL = PW'(QUEUESIZE - AF_MARGIN);

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW-1:0] wr_ptr_nxt, rd_ptr_nxt;
    logic [PW-1:0] level_q;
    logic          is_empty, is_full;
    logic          push_acc, pop_acc;
    logic          ovf_set, unf_set;

    // Extra pointer MSB distinguishes full from empty when the slot bits match.
    assign is_empty = (wr_ptr == rd_ptr);
    assign is_full  = (wr_ptr[QUEUECNTBITS] != rd_ptr[QUEUECNTBITS]) &&
                      (wr_ptr[QUEUECNTBITS-1:0] == rd_ptr[QUEUECNTBITS-1:0]);

    // A push into a full queue is still taken when the head leaves the same cycle.
    assign push_acc = !flush && push && (!is_full || pop);
    assign pop_acc  = !flush && pop && !is_empty;
    assign ovf_set  = !flush && push && is_full && !pop;
    assign unf_set  = !flush && pop && is_empty;

    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        if (flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
        end else begin
            if (push_acc) wr_ptr_nxt = wr_ptr + PW'(1);
            if (pop_acc)  rd_ptr_nxt = rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level_q       <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr_nxt;
            rd_ptr  <= rd_ptr_nxt;
            level_q <= wr_ptr_nxt - rd_ptr_nxt;
            // Setting an error beats clearing it in the same cycle.
            if (ovf_set)      err_overflow <= 1'b1;
            else if (err_clr) err_overflow <= 1'b0;
            if (unf_set)      err_underflow <= 1'b1;
            else if (err_clr) err_underflow <= 1'b0;
        end
    end

    assign wr_en       = push_acc;
    assign wr_idx      = wr_ptr[QUEUECNTBITS-1:0];
    assign rd_idx      = rd_ptr[QUEUECNTBITS-1:0];
    assign not_empty   = !is_empty;
    assign full        = is_full;
    assign level       = level_q;
    assign almost_full = (level_q >= AF_LEVEL);

endmodule

// File: rtl/icache_req_fifo.sv
// -----------------------------------------------------------------------------
// icache_req_fifo
//   Request FIFO between the icache miss/prefetch logic and the memory-fetch
//   FSM. Each entry holds {addr, wordlen}; the head entry is shown ahead on
//   pop_addr/pop_wordlen while not_empty is high.
//   Ports:
//     clk      rising-edge clock
//     reset_n  asynchronous active-low reset (storage itself is not reset)
//     bus      icache_req_fifo_if slave: push/pop/flush/err_clr in,
//              head entry, level, full/almost_full and sticky errors out
// -----------------------------------------------------------------------------
module icache_req_fifo
    import icache_req_fifo_pkg::*;
#(
    parameter int ADDRBITS     = 32,
    parameter int QUEUECNTBITS = 3,
    parameter int AF_MARGIN    = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    icache_req_fifo_if.slave    bus
);
    localparam int QUEUESIZE = 1 << QUEUECNTBITS;
    localparam int ENTRY_W   = icache_qreq_w(ADDRBITS);

    logic [ENTRY_W-1:0]      mem [QUEUESIZE];
    logic [ENTRY_W-1:0]      head;
    logic                    wr_en;
    logic [QUEUECNTBITS-1:0] wr_idx;
    logic [QUEUECNTBITS-1:0] rd_idx;
    logic                    not_empty;
    logic                    full;
    logic                    almost_full;
    logic [QUEUECNTBITS:0]   level;
    logic                    err_overflow;
    logic                    err_underflow;

    icache_fifo_ctrl #(
        .QUEUECNTBITS (QUEUECNTBITS),
        .AF_MARGIN    (AF_MARGIN)
    ) u_ctrl (
        .clk           (clk),
        .reset_n       (reset_n),
        .flush         (bus.flush),
        .push          (bus.push),
        .pop           (bus.pop),
        .err_clr       (bus.err_clr),
        .wr_en         (wr_en),
        .wr_idx        (wr_idx),
        .rd_idx        (rd_idx),
        .not_empty     (not_empty),
        .full          (full),
        .almost_full   (almost_full),
        .level         (level),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    // Data-only storage: no reset, contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= {bus.push_addr, bus.push_wordlen};
    end

    // Show-ahead read: head slot is always driven, qualified by not_empty.
    assign head              = mem[rd_idx];
    assign bus.pop_addr      = head[ENTRY_W-1:2];
    assign bus.pop_wordlen   = head[1:0];
    assign bus.not_empty     = not_empty;
    assign bus.full          = full;
    assign bus.almost_full   = almost_full;
    assign bus.level         = level;
    assign bus.err_overflow  = err_overflow;
    assign bus.err_underflow = err_underflow;

endmodule

// File: tb/tb_icache_req_fifo.sv
// -----------------------------------------------------------------------------
// tb_icache_req_fifo
//   Directed bench for icache_req_fifo with a queue-based reference model
//   (8-entry FIFO, AF_MARGIN=2) and per-cycle output comparison.
// -----------------------------------------------------------------------------
module tb_icache_req_fifo;
    import icache_req_fifo_pkg::*;

    localparam int AW    = 32;
    localparam int QCB   = 3;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b1;

    icache_req_fifo_if #(.ADDRBITS(AW), .QUEUECNTBITS(QCB)) bus ();

    icache_req_fifo #(
        .ADDRBITS     (AW),
        .QUEUECNTBITS (QCB),
        .AF_MARGIN    (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [AW-1:0] a;
        logic [1:0]    w;
    } ent_t;

    ent_t mq[$];
    logic m_ovf = 1'b0;
    logic m_unf = 1'b0;

    task automatic model_step();
        int  n;
        bit  ovf, unf;
        ent_t e;
        n   = mq.size();
        ovf = 1'b0;
        unf = 1'b0;
        if (bus.flush) begin
            mq.delete();
        end else begin
            if (bus.push && n == DEPTH && !bus.pop) ovf = 1'b1;
            if (bus.pop && n == 0) unf = 1'b1;
            if (bus.pop && n > 0) void'(mq.pop_front());
            if (bus.push && (n < DEPTH || bus.pop)) begin
                e.a = bus.push_addr;
                e.w = bus.push_wordlen;
                mq.push_back(e);
            end
        end
        if (ovf) m_ovf = 1'b1; else if (bus.err_clr) m_ovf = 1'b0;
        if (unf) m_unf = 1'b1; else if (bus.err_clr) m_unf = 1'b0;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("level",         64'(bus.level),         64'(mq.size()));
        chk("not_empty",     64'(bus.not_empty),     64'(mq.size() != 0));
        chk("full",          64'(bus.full),          64'(mq.size() == DEPTH));
        chk("almost_full",   64'(bus.almost_full),   64'(mq.size() >= DEPTH - 2));
        chk("err_overflow",  64'(bus.err_overflow),  64'(m_ovf));
        chk("err_underflow", 64'(bus.err_underflow), 64'(m_unf));
        if (mq.size() != 0) begin
            chk("pop_addr",    64'(bus.pop_addr),    64'(mq[0].a));
            chk("pop_wordlen", 64'(bus.pop_wordlen), 64'(mq[0].w));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic ps, input logic [AW-1:0] a, input logic [1:0] w,
                       input logic pp, input logic fl, input logic clr);
        bus.push         = ps;
        bus.push_addr    = a;
        bus.push_wordlen = w;
        bus.pop          = pp;
        bus.flush        = fl;
        bus.err_clr      = clr;
        @(posedge clk);
        #1;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.flush   = 1'b0;
        bus.err_clr = 1'b0;
    endtask

    initial begin
        bus.push         = 1'b0;
        bus.push_addr    = '0;
        bus.push_wordlen = 2'b00;
        bus.pop          = 1'b0;
        bus.flush        = 1'b0;
        bus.err_clr      = 1'b0;
        #1 reset_n = 1'b0;
        #20;
        chk("rst_level",     64'(bus.level), 64'd0);
        chk("rst_not_empty", 64'(bus.not_empty), 64'd0);
        chk("rst_full",      64'(bus.full), 64'd0);
        chk("rst_af",        64'(bus.almost_full), 64'd0);
        chk("rst_errs",      64'({bus.err_overflow, bus.err_underflow}), 64'd0);
        reset_n = 1'b1;

        // 1: fill to full, almost_full from level 6
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, AW'(32'h100 + 4 * i), ICACHE_WL_WORD, 1'b0, 1'b0, 1'b0);
            chk("t1_level", 64'(bus.level), 64'(i + 1));
            chk("t1_af",    64'(bus.almost_full), 64'(i + 1 >= 6));
        end
        chk("t1_full", 64'(bus.full), 64'd1);

        // 2: push while full is dropped
        cyc(1'b1, AW'(32'hDEAD), ICACHE_WL_WORD, 1'b0, 1'b0, 1'b0);
        chk("t2_ovf",   64'(bus.err_overflow), 64'd1);
        chk("t2_level", 64'(bus.level), 64'd8);

        // 1 (cont.): drain in order, 0xDEAD never shows up
        for (int i = 0; i < 8; i++) begin
            chk("t1_pop_addr", 64'(bus.pop_addr), 64'(32'h100 + 4 * i));
            chk("t1_pop_wl",   64'(bus.pop_wordlen), 64'(2'b10));
            cyc(1'b0, '0, 2'b00, 1'b1, 1'b0, 1'b0);
        end
        chk("t1_empty", 64'(bus.not_empty), 64'd0);

        // 3: pop while empty, then clear
        cyc(1'b0, '0, 2'b00, 1'b1, 1'b0, 1'b0);
        chk("t3_unf",   64'(bus.err_underflow), 64'd1);
        chk("t3_level", 64'(bus.level), 64'd0);
        cyc(1'b0, '0, 2'b00, 1'b0, 1'b0, 1'b1);
        chk("t3_clr", 64'({bus.err_overflow, bus.err_underflow}), 64'd0);

        // 4: steady push+pop at level 3 across pointer wrap
        for (int i = 0; i < 3; i++)
            cyc(1'b1, AW'(32'h200 + i), ICACHE_WL_HALF, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            cyc(1'b1, AW'(32'h300 + k), 2'(k), 1'b1, 1'b0, 1'b0);
            chk("t4_level", 64'(bus.level), 64'd3);
        end
        chk("t4_head", 64'(bus.pop_addr), 64'h311);

        // 5: push+pop when full, then push+pop when empty
        for (int i = 0; i < 5; i++)
            cyc(1'b1, AW'(32'h400 + i), ICACHE_WL_BYTE, 1'b0, 1'b0, 1'b0);
        chk("t5_full", 64'(bus.full), 64'd1);
        cyc(1'b1, AW'(32'h500), ICACHE_WL_RSVD, 1'b1, 1'b0, 1'b0);
        chk("t5_full_level", 64'(bus.level), 64'd8);
        chk("t5_full_ovf",   64'(bus.err_overflow), 64'd0);
        for (int i = 0; i < 8; i++)
            cyc(1'b0, '0, 2'b00, 1'b1, 1'b0, 1'b0);
        chk("t5_drained", 64'(bus.level), 64'd0);
        cyc(1'b1, AW'(32'h600), ICACHE_WL_WORD, 1'b1, 1'b0, 1'b0);
        chk("t5_empty_level", 64'(bus.level), 64'd1);
        chk("t5_empty_unf",   64'(bus.err_underflow), 64'd1);
        chk("t5_empty_head",  64'(bus.pop_addr), 64'h600);

        // 6: flush overrides push/pop, then async reset mid-burst
        cyc(1'b0, '0, 2'b00, 1'b0, 1'b1, 1'b1);
        chk("t6_flush0", 64'(bus.level), 64'd0);
        for (int i = 0; i < 5; i++)
            cyc(1'b1, AW'(32'h700 + i), ICACHE_WL_WORD, 1'b0, 1'b0, 1'b0);
        chk("t6_level5", 64'(bus.level), 64'd5);
        cyc(1'b1, AW'(32'h7FF), ICACHE_WL_WORD, 1'b1, 1'b1, 1'b0);
        chk("t6_fl_level", 64'(bus.level), 64'd0);
        chk("t6_fl_ne",    64'(bus.not_empty), 64'd0);
        chk("t6_fl_errs",  64'({bus.err_overflow, bus.err_underflow}), 64'd0);
        cyc(1'b0, '0, 2'b00, 1'b1, 1'b0, 1'b0);
        chk("t6_unf", 64'(bus.err_underflow), 64'd1);
        for (int i = 0; i < 3; i++)
            cyc(1'b1, AW'(32'h800 + 4 * i), ICACHE_WL_WORD, 1'b0, 1'b0, 1'b0);
        bus.push      = 1'b1;
        bus.push_addr = AW'(32'h80C);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_level", 64'(bus.level), 64'd0);
        chk("t6_rst_ne",    64'(bus.not_empty), 64'd0);
        chk("t6_rst_full",  64'(bus.full), 64'd0);
        chk("t6_rst_af",    64'(bus.almost_full), 64'd0);
        chk("t6_rst_errs",  64'({bus.err_overflow, bus.err_underflow}), 64'd0);
        bus.push = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
